lights_leds: RTL and testbench

LIGHTS_LEDS -- requirements
Module: lights_leds

---
 rtl/lights_leds.sv | 108 ++++++++++
 tb/tb_lights_leds.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/lights_leds.sv
// Avalon-MM LED output port with data, outset/outclear and an optional blink
// engine compiled in only when LIGHTS_LEDS_BLINK_EN is defined.
`timescale 1ns/1ps

module lights_leds #(
  parameter int          DATA_WIDTH  = 4,
  parameter logic [31:0] RESET_VALUE = 32'd0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [2:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_port
);

  localparam logic [2:0] ADDR_DATA   = 3'd0;
  localparam logic [2:0] ADDR_MASK   = 3'd1;
  localparam logic [2:0] ADDR_PERIOD = 3'd2;
  localparam logic [2:0] ADDR_OUTSET = 3'd4;
  localparam logic [2:0] ADDR_OUTCLR = 3'd5;

  localparam logic [DATA_WIDTH-1:0] RST_DATA = RESET_VALUE[DATA_WIDTH-1:0];

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_bits;
  logic [DATA_WIDTH-1:0] data;
  logic [DATA_WIDTH-1:0] blink_off;
  logic [31:0]           read_mux;
  logic                  unused_writedata;

  assign wr_en            = chipselect & ~write_n;
  assign wr_bits          = writedata[DATA_WIDTH-1:0];
  assign unused_writedata = ^writedata;

`ifdef LIGHTS_LEDS_BLINK_EN
  logic [DATA_WIDTH-1:0] mask;
  logic [15:0]           period;
  logic [15:0]           prescaler;
  logic                  phase;

  // A period write restarts the blink cycle and wins over a same-cycle wrap.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mask      <= '0;
      period    <= '0;
      prescaler <= '0;
      phase     <= 1'b1;
    end else begin
      if (wr_en && address == ADDR_MASK)
        mask <= wr_bits;
      if (wr_en && address == ADDR_PERIOD) begin
        period    <= writedata[15:0];
        prescaler <= '0;
        phase     <= 1'b1;
      end else if (period == 16'd0) begin
        prescaler <= '0;
        phase     <= 1'b1;
      end else if (prescaler == period) begin
        prescaler <= '0;
        phase     <= ~phase;
      end else begin
        prescaler <= prescaler + 16'd1;
      end
    end
  end

  assign blink_off = mask & {DATA_WIDTH{~phase}};
`else
  assign blink_off = '0;
`endif

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    read_mux = '0;
    case (address)
      ADDR_DATA:   read_mux[DATA_WIDTH-1:0] = data;
`ifdef LIGHTS_LEDS_BLINK_EN
      ADDR_MASK:   read_mux[DATA_WIDTH-1:0] = mask;
      ADDR_PERIOD: read_mux[15:0]           = period;
`endif
      default:     read_mux = '0;
    endcase
  end

  // NOTE: state updates use non-blocking assignments and reset is sampled on the clock edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data     <= RST_DATA;
      readdata <= '0;
      out_port <= RST_DATA;
    end else begin
      if (wr_en) begin
        case (address)
          ADDR_DATA:   data <= wr_bits;
          ADDR_OUTSET: data <= data | wr_bits;
          ADDR_OUTCLR: data <= data & ~wr_bits;
          default:     data <= data;
        endcase
      end
      readdata <= read_mux;
      out_port <= data & ~blink_off;
    end
  end

endmodule

// File: tb/tb_lights_leds.sv
// Randomized scoreboard bench for lights_leds; follows LIGHTS_LEDS_BLINK_EN.
`timescale 1ns/1ps

module tb_lights_leds;

  localparam int          DW = 4;
  localparam logic [31:0] RV = 32'd0;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [2:0]    address = '0;
  logic          chipselect = 1'b0;
  logic          write_n = 1'b1;
  logic [31:0]   writedata = '0;
  logic [31:0]   readdata;
  logic [DW-1:0] out_port;

  lights_leds #(.DATA_WIDTH(DW), .RESET_VALUE(RV)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0]   rd;
    logic [DW-1:0] op;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: register contents plus the edge count of the last blink restart.
  // Phase is derived arithmetically from elapsed edges rather than a prescaler.
  logic [DW-1:0] m_data   = RV[DW-1:0];
  logic [DW-1:0] m_mask   = '0;
  logic [15:0]   m_period = '0;
  longint        edge_cnt = 0;
  longint        t0       = 0;

  function automatic logic model_phase();
    if (m_period == 16'd0) return 1'b1;
    return (((edge_cnt - t0) / (longint'(m_period) + 1)) % 2) == 0;
  endfunction

  task automatic model_edge();
    exp_t          e;
    logic [DW-1:0] p_data = m_data;
    logic [DW-1:0] p_mask = m_mask;
    logic          p_ph   = model_phase();
    logic [31:0]   rd     = '0;
    logic          wr     = chipselect && !write_n;
    case (address)
      3'd0: rd = 32'(p_data);
`ifdef LIGHTS_LEDS_BLINK_EN
      3'd1: rd = 32'(p_mask);
      3'd2: rd = 32'(m_period);
`endif
      default: rd = '0;
    endcase
    edge_cnt++;
    if (!reset_n) begin
      m_data = RV[DW-1:0]; m_mask = '0; m_period = '0; t0 = edge_cnt;
      e.rd = '0; e.op = RV[DW-1:0];
    end else begin
      e.rd = rd;
      e.op = p_data & ~(p_mask & {DW{~p_ph}});
      if (wr) begin
        case (address)
          3'd0: m_data = writedata[DW-1:0];
          3'd4: m_data = p_data | writedata[DW-1:0];
          3'd5: m_data = p_data & ~writedata[DW-1:0];
`ifdef LIGHTS_LEDS_BLINK_EN
          3'd1: m_mask = writedata[DW-1:0];
          3'd2: begin m_period = writedata[15:0]; t0 = edge_cnt; end
`endif
          default: ;
        endcase
      end
    end
    sb.push_back(e);
  endtask

  task automatic drive(input bit rst, input bit cs, input bit wn,
                       input logic [2:0] a, input logic [31:0] d);
    reset_n = rst; chipselect = cs; write_n = wn; address = a; writedata = d;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    drive(1'b1, 1'b1, 1'b0, a, d);
  endtask

  task automatic rd_idle(input logic [2:0] a, input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b1, a, $urandom);
  endtask

  // Monitor: the DUT presents new outputs after every edge; compare mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("readdata", 64'(readdata), 64'(e.rd));
        check("out_port", 64'(out_port), 64'(e.op));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]  a;
    logic [31:0] d;
    drive(1'b0, 1'b1, 1'b0, 3'd0, 32'hF);
    drive(1'b0, 1'b0, 1'b1, 3'd0, 32'h0);
    rd_idle(3'd0, 2);

    // Plain data write, then outset/outclear and their read-as-zero addresses.
    wr(3'd0, 32'hA);
    rd_idle(3'd0, 3);
    wr(3'd0, 32'h3);
    wr(3'd4, 32'h8);
    wr(3'd5, 32'h1);
    rd_idle(3'd4, 1);
    rd_idle(3'd5, 1);
    rd_idle(3'd0, 2);
    wr(3'd3, 32'hF);
    wr(3'd7, 32'hF);
    rd_idle(3'd0, 2);

`ifdef LIGHTS_LEDS_BLINK_EN
    wr(3'd0, 32'hF);
    wr(3'd1, 32'h5);
    wr(3'd2, 32'd3);
    rd_idle(3'd0, 20);
    // Period rewrite landing exactly on a wrap edge (4 edges after the last restart).
    wr(3'd2, 32'd3);
    rd_idle(3'd2, 3);
    wr(3'd2, 32'd3);
    rd_idle(3'd1, 10);
    drive(1'b0, 1'b1, 1'b0, 3'd0, 32'h7);
    rd_idle(3'd0, 3);
    rd_idle(3'd1, 1);
    rd_idle(3'd2, 1);
`else
    wr(3'd0, 32'h6);
    wr(3'd1, 32'h5);
    rd_idle(3'd1, 3);
    wr(3'd2, 32'h3);
    rd_idle(3'd2, 6);
`endif

    for (int i = 0; i < 3000; i++) begin
      a = 3'($urandom_range(0, 7));
      d = $urandom;
      if (a == 3'd2) d = $urandom_range(0, 6);
      drive(($urandom_range(0, 99) != 0), $urandom_range(0, 1) != 0,
            $urandom_range(0, 2) == 0, a, d);
    end

    rd_idle(3'd0, 1);
    @(negedge clk);
    @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
